seq_detect_param: RTL and testbench

- Parametrised Moore serial pattern detector; next generation of the team's fixed 1011 detector.
- Adds generic pattern width and value, runtime pattern reload, overlap/non-overlap mode, an input-valid qualifier and an exposed state.
- Sits on a serial bit stream ahead of frame/sync logic.
- The match flag depends only on the current state (Moore).

---
 rtl/seq_detect_param_if.sv | 26 ++
 rtl/seq_detect_param.sv | 105 ++++++++++
 tb/tb_seq_detect_param.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_param_if.sv
// rtl/seq_detect_param_if.sv - serial-in / match-out bundle for seq_detect_param
interface seq_detect_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  localparam int ST_W = $clog2(PAT_W + 1);

  logic             in;
  logic             in_valid;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             cnt_clr;
  logic             out;
  logic [ST_W-1:0]  state;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output in, in_valid, pat_load, pat_in, cnt_clr,
    input  out, state, match_cnt
  );

  modport slave (
    input  in, in_valid, pat_load, pat_in, cnt_clr,
    output out, state, match_cnt
  );
endinterface

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised Moore serial pattern detector
// Optional saturating match counter enabled by defining SEQDET_CNT_EN.
module seq_detect_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(4'b1011),
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  seq_detect_param_if.slave bus
);
  localparam int ST_W   = $clog2(PAT_W + 1);
  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [ST_W-1:0] FULL = ST_W'(PAT_W);

  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [ST_W-1:0]   state_q, state_d;
  logic [PAT_W-1:0]  win;
  logic [ST_W-1:0]   best;
  logic              accept;

  assign accept = bus.in_valid & ~bus.pat_load;

  // Longest pattern prefix that is a suffix of the accepted bits plus the new one.
  always_comb begin
    logic hit;
    win  = {hist_q, bus.in};
    best = '0;
    for (int j = 1; j <= PAT_W; j++) begin
      hit = (j <= int'(fill_q) + 1);
      for (int i = 0; i < j; i++) begin
        if (win[i] != pat_q[PAT_W-j+i]) hit = 1'b0;
      end
      if (hit) best = ST_W'(j);
    end
  end

  always_comb begin
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    state_d = state_q;
    if (bus.pat_load) begin
      pat_d   = bus.pat_in;
      hist_d  = '0;
      fill_d  = '0;
      state_d = '0;
    end else if (bus.in_valid) begin
      if (OVERLAP == 0 && state_q == FULL) begin
        // Non-overlap: the completed match is forgotten before this bit is used.
        hist_d  = (PAT_W-1)'(bus.in);
        fill_d  = FILL_W'(1);
        state_d = ST_W'(bus.in == pat_q[PAT_W-1]);
      end else begin
        hist_d  = win[PAT_W-2:0];
        fill_d  = (fill_q == FILL_W'(PAT_W-1)) ? fill_q : fill_q + 1'b1;
        state_d = best;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_q   <= PATTERN;
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= '0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      state_q <= state_d;
    end
  end

  assign bus.out   = (state_q == FULL);
  assign bus.state = state_q;

`ifdef SEQDET_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (accept && state_d == FULL && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign bus.match_cnt = cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt    = bus.cnt_clr ^ accept;
  assign bus.match_cnt = CNT_W'(0);
`endif
endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - bench for seq_detect_param: default, non-overlap and 2-bit counter instances
module tb_seq_detect_param;
  logic       clk = 1'b0;
  logic       rst;
  logic       t_in, t_valid, t_load, t_clr;
  logic [3:0] t_pat;
  int         n_pass = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  seq_detect_param_if #(.PAT_W(4), .CNT_W(8)) if_a ();
  seq_detect_param_if #(.PAT_W(4), .CNT_W(8)) if_b ();
  seq_detect_param_if #(.PAT_W(4), .CNT_W(2)) if_c ();

  assign if_a.in = t_in;  assign if_a.in_valid = t_valid; assign if_a.pat_load = t_load;
  assign if_a.pat_in = t_pat; assign if_a.cnt_clr = t_clr;
  assign if_b.in = t_in;  assign if_b.in_valid = t_valid; assign if_b.pat_load = t_load;
  assign if_b.pat_in = t_pat; assign if_b.cnt_clr = t_clr;
  assign if_c.in = t_in;  assign if_c.in_valid = t_valid; assign if_c.pat_load = t_load;
  assign if_c.pat_in = t_pat; assign if_c.cnt_clr = t_clr;

  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  // Reference model: accepted bits kept as a number (newest in bit 0) since the last clear.
  logic [3:0]  m_pat;
  logic [31:0] m_bits [3];
  int          m_len  [3];
  int          m_st   [3];
  int          m_cnt  [3];
  int          m_ovl  [3] = '{1, 0, 1};
  int          m_cmax [3] = '{255, 255, 3};

  function automatic int prefix_len(int d);
    int top;
    top = (m_len[d] < 4) ? m_len[d] : 4;
    for (int j = top; j >= 1; j--) begin
      if ((m_bits[d] & ((32'd1 << j) - 1)) == 32'(m_pat >> (4 - j))) return j;
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_total++;
    assert (obs === 32'(exp)) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int exp_cnt(int d);
`ifdef SEQDET_CNT_EN
    return m_cnt[d];
`else
    return 0 * d;
`endif
  endfunction

  task automatic step(input logic r, input logic b, input logic v, input logic l,
                      input logic [3:0] p, input logic c);
    rst = r; t_in = b; t_valid = v; t_load = l; t_pat = p; t_clr = c;
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (!r) begin
        m_bits[d] = 0; m_len[d] = 0; m_st[d] = 0; m_cnt[d] = 0;
      end else if (l) begin
        m_bits[d] = 0; m_len[d] = 0; m_st[d] = 0;
        if (c) m_cnt[d] = 0;
      end else if (v) begin
        if (m_ovl[d] == 0 && m_st[d] == 4) begin
          m_bits[d] = 0; m_len[d] = 0;
        end
        m_bits[d] = (m_bits[d] << 1) | 32'(b);
        m_len[d]++;
        m_st[d] = prefix_len(d);
        if (c) m_cnt[d] = 0;
        else if (m_st[d] == 4 && m_cnt[d] < m_cmax[d]) m_cnt[d]++;
      end else if (c) begin
        m_cnt[d] = 0;
      end
    end
    if (!r) m_pat = 4'b1011;
    else if (l) m_pat = p;
    #1;
    chk("a_state", 32'(if_a.state), m_st[0]);
    chk("a_out",   32'(if_a.out), int'(m_st[0] == 4));
    chk("a_cnt",   32'(if_a.match_cnt), exp_cnt(0));
    chk("b_state", 32'(if_b.state), m_st[1]);
    chk("b_out",   32'(if_b.out), int'(m_st[1] == 4));
    chk("b_cnt",   32'(if_b.match_cnt), exp_cnt(1));
    chk("c_state", 32'(if_c.state), m_st[2]);
    chk("c_out",   32'(if_c.out), int'(m_st[2] == 4));
    chk("c_cnt",   32'(if_c.match_cnt), exp_cnt(2));
  endtask

  task automatic bit_in(input logic b);
    step(1'b1, b, 1'b1, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  logic [6:0] s1     = 7'b1011011;
  int         st_a[7] = '{1, 2, 3, 4, 2, 3, 4};
  int         st_b[7] = '{1, 2, 3, 4, 0, 1, 1};
  int         sat[5]  = '{1, 2, 3, 3, 3};
  logic [3:0] p1011  = 4'b1011;
  logic [3:0] p0110  = 4'b0110;

  initial begin
    rst = 1'b0; t_in = 1'b0; t_valid = 1'b0; t_load = 1'b0; t_pat = '0; t_clr = 1'b0;
    m_pat = 4'b1011;
    do_reset();
    chk("rst_state", 32'(if_a.state), 0);
    chk("rst_out",   32'(if_a.out), 0);
    chk("rst_cnt",   32'(if_a.match_cnt), 0);

    // 1011011 on overlap (a) and non-overlap (b) instances
    for (int i = 6; i >= 0; i--) begin
      bit_in(s1[i]);
      chk("ovl_seq", 32'(if_a.state), st_a[6-i]);
      chk("novl_seq", 32'(if_b.state), st_b[6-i]);
    end
`ifdef SEQDET_CNT_EN
    chk("novl_cnt", 32'(if_b.match_cnt), 1);
`endif

    // valid toggling: the match holds through the idle cycle after it
    do_reset();
    for (int i = 3; i >= 0; i--) begin
      bit_in(p1011[i]);
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    end
    chk("hold_out", 32'(if_a.out), 1);

    // pattern reload drops the concurrent bit
    do_reset();
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    chk("pre_load_state", 32'(if_a.state), 3);
    step(1'b1, 1'b1, 1'b1, 1'b1, p0110, 1'b0);
    chk("load_state", 32'(if_a.state), 0);
    for (int i = 3; i >= 0; i--) bit_in(p0110[i]);
    chk("load_match", 32'(if_a.out), 1);

    // reset mid-pattern
    do_reset();
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    do_reset();
    chk("midrst_state", 32'(if_a.state), 0);
    bit_in(1'b1);
    chk("midrst_one", 32'(if_a.state), 1);
    chk("midrst_out", 32'(if_a.out), 0);

    // five matches into a 2-bit counter, then clear on a match edge
    do_reset();
    for (int m = 0; m < 5; m++) begin
      for (int i = 3; i >= 0; i--) bit_in(p1011[i]);
`ifdef SEQDET_CNT_EN
      chk("sat_cnt", 32'(if_c.match_cnt), sat[m]);
`else
      chk("no_cnt", 32'(if_c.match_cnt), 0);
`endif
    end
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    chk("clr_cnt", 32'(if_c.match_cnt), 0);
    chk("clr_out", 32'(if_c.out), 1);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 59) != 0), 1'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 29) == 0), 4'($urandom), ($urandom_range(0, 19) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
